// File: rtl/witness_pkg.sv
// Shared definitions for the constraint witness generator.
//   state_t       : search FSM states
//   A_W_DEF/B_W_DEF : default operand widths
//   golden_check  : internal reference predicate, (a - b) mod 2^aw == all-ones
package witness_pkg;

    localparam int A_W_DEF = 16;
    localparam int B_W_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Operands arrive zero-extended to 32 bits; aw selects the modulus, so the
    // function serves any A_W up to 32 without being parameterised.
    function automatic logic golden_check(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned aw);
        logic [31:0] diff;
        logic [31:0] mask;
        diff = a - b;
        mask = (aw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << aw) - 32'd1);
        return (diff & mask) == mask;
    endfunction

endpackage

// File: rtl/witness_cand_step.sv
// Candidate stepping counters.
//   clk, rst_n      : clock, asynchronous active-low reset
//   load            : capture seed_a/seed_b as candidate 0
//   adv             : step to the next candidate (a += 1, b += 2, both wrapping)
//   seed_a, seed_b  : first candidate
//   cand_a, cand_b  : current candidate (registered)
module witness_cand_step #(
    parameter int A_W = 16,
    parameter int B_W = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           adv,
    input  logic [A_W-1:0] seed_a,
    input  logic [B_W-1:0] seed_b,
    output logic [A_W-1:0] cand_a,
    output logic [B_W-1:0] cand_b
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_a <= '0;
            cand_b <= '0;
        end else if (load) begin
            cand_a <= seed_a;
            cand_b <= seed_b;
        end else if (adv) begin
            // Wrap is intentional and silent: plain modulo arithmetic.
            cand_a <= cand_a + A_W'(1);
            cand_b <= cand_b + B_W'(2);
        end
    end

endmodule

// File: rtl/constraint_witness_gen.sv
// Constraint witness generator: walks candidates (seed_a + k, seed_b + 2k),
// offers each to an external checker over a valid/ready handshake, and stops
// at the first candidate the checker accepts or when max_iter is exhausted.
// Each external verdict is compared against an internal golden check; any
// disagreement sets the sticky mismatch flag (the external verdict still wins).
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : one-cycle search request, honoured only when idle
//   seed_a, seed_b        : first candidate
//   max_iter              : candidate budget (0 = finish without candidates)
//   cand_valid/cand_ready : candidate handshake to the checker
//   cand_a, cand_b        : candidate on offer
//   res_valid, res_sat    : checker verdict
//   busy                  : search in progress
//   done                  : one-cycle completion pulse
//   found, sol_a, sol_b   : outcome and witness, held until the next start
//   iter_cnt              : candidates judged in the current/last search
//   mismatch              : sticky external/internal verdict disagreement
module constraint_witness_gen
    import witness_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [A_W-1:0] seed_a,
    input  logic [B_W-1:0] seed_b,
    input  logic [15:0]    max_iter,
    output logic           cand_valid,
    input  logic           cand_ready,
    output logic [A_W-1:0] cand_a,
    output logic [B_W-1:0] cand_b,
    input  logic           res_valid,
    input  logic           res_sat,
    output logic           busy,
    output logic           done,
    output logic           found,
    output logic [A_W-1:0] sol_a,
    output logic [B_W-1:0] sol_b,
    output logic [15:0]    iter_cnt,
    output logic           mismatch
);

    state_t      state;
    logic [15:0] max_iter_q;
    logic        step_load;
    logic        step_adv;
    logic        last_cand;
    logic        golden;

    assign last_cand = (iter_cnt + 16'd1) == max_iter_q;
    assign golden    = golden_check(32'(cand_a), 32'(cand_b), A_W);

    // Counter controls are decoded from the same conditions the FSM uses, so
    // the counters move on exactly the edges where the FSM changes candidate.
    always_comb begin
        step_load = 1'b0;
        step_adv  = 1'b0;
        if (state == ST_IDLE && start)
            step_load = 1'b1;
        if (state == ST_WAIT && res_valid && !res_sat && !last_cand)
            step_adv = 1'b1;
    end

    witness_cand_step #(
        .A_W (A_W),
        .B_W (B_W)
    ) u_cand_step (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (step_load),
        .adv    (step_adv),
        .seed_a (seed_a),
        .seed_b (seed_b),
        .cand_a (cand_a),
        .cand_b (cand_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            max_iter_q <= '0;
            cand_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            sol_a      <= '0;
            sol_b      <= '0;
            iter_cnt   <= '0;
            mismatch   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        max_iter_q <= max_iter;
                        found      <= 1'b0;
                        sol_a      <= '0;
                        sol_b      <= '0;
                        iter_cnt   <= '0;
                        mismatch   <= 1'b0;
                        if (max_iter == 16'd0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= ST_ISSUE;
                            cand_valid <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (cand_ready) begin
                        state      <= ST_WAIT;
                        cand_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (res_valid) begin
                        iter_cnt <= iter_cnt + 16'd1;
                        if (res_sat != golden)
                            mismatch <= 1'b1;
                        if (res_sat) begin
                            sol_a <= cand_a;
                            sol_b <= cand_b;
                            found <= 1'b1;
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (last_cand) begin
                            found <= 1'b0;
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state      <= ST_ISSUE;
                            cand_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/constraint_witness_gen.md
CONSTRAINT_WITNESS_GEN -- requirements
Module: constraint_witness_gen

Interface
REQ-001 SHALL have parameter A_W, default 16, width of candidate operand A (var_20 domain).
REQ-002 SHALL have parameter B_W, default 12, width of candidate operand B (var_16 domain).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request to begin a search; ignored unless idle.
REQ-006 seed_a  in  A_W  first candidate A.
REQ-007 seed_b  in  B_W  first candidate B.
REQ-008 max_iter  in  16  candidate budget; 0 means no candidates.
REQ-009 cand_valid  out  1  candidate offered to the external checker.
REQ-010 cand_ready  in  1  checker accepts the candidate.
REQ-011 cand_a / cand_b  out  A_W / B_W  current candidate.
REQ-012 res_valid  in  1  checker verdict valid.
REQ-013 res_sat  in  1  checker verdict: constraint satisfied.
REQ-014 busy  out  1  search in progress.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 found / sol_a / sol_b  out  1 / A_W / B_W  result and witness; held until next start.
REQ-017 iter_cnt  out  16  candidates judged in the current or last search.
REQ-018 mismatch  out  1  sticky: external verdict disagreed with internal golden check.

Function
REQ-019 Candidate k (k from 0) SHALL be cand_a = seed_a + k mod 2^A_W and cand_b = seed_b + 2k mod 2^B_W.
REQ-020 Golden check SHALL be true iff (cand_a - zero-extended cand_b) mod 2^A_W equals all-ones.
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-022 IDLE with start: latch seeds and max_iter, clear found/sol/iter_cnt/mismatch, and go to ISSUE, or to DONE with found=0 if max_iter=0.
REQ-023 ISSUE: cand_valid=1, with cand_a/cand_b stable until the cycle cand_ready=1, then go to WAIT.
REQ-024 WAIT: cand_valid=0; on res_valid, iter_cnt increments by 1.
REQ-025 WAIT with res_valid: if res_sat != golden check, set mismatch.
REQ-026 WAIT with res_valid and res_sat=1: latch sol_a/sol_b, found=1, go to DONE.
REQ-027 WAIT with res_valid, res_sat=0, and iter_cnt+1 = max_iter: found=0, go to DONE.
REQ-028 WAIT with res_valid, res_sat=0, otherwise: advance k, go to ISSUE.
REQ-029 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-030 busy SHALL be 1 in ISSUE and WAIT, and 0 otherwise.
REQ-031 res_valid outside WAIT SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-032 Operand wrap SHALL be silent modulo arithmetic, with no flag.
REQ-033 A result SHALL be accepted on res_sat alone, even when mismatch is set.

Reset
REQ-034 rst_n low SHALL immediately force IDLE and drive all outputs to 0, including mid-handshake.
REQ-035 After reset release, no candidate SHALL be issued before a new start.

Structure
REQ-036 State enum and the golden-check function SHALL live in shared package witness_pkg; A_W/B_W defaults SHALL be package constants.
REQ-037 Candidate stepping SHALL be sub-module witness_cand_step (registered a/b counters with load and advance).

Verification
REQ-038 seed_a=0x0000, seed_b=0x001, max_iter=10, checker = golden -> 1 candidate; found=1, sol=(0x0000,0x001), iter_cnt=1, mismatch=0.
REQ-039 seed_a=0x0003, seed_b=0x000, max_iter=10 -> candidates (3,0),(4,2),(5,4),(6,6),(7,8); found=1, sol=(0x0007,0x008), iter_cnt=5.
REQ-040 Same seeds, max_iter=3 -> 3 candidates, found=0, iter_cnt=3, done pulse once; max_iter=0 -> no cand_valid, done one cycle after start.
REQ-041 cand_ready held low 4 cycles while cand_valid=1 -> cand_a/cand_b unchanged; spurious res_valid in ISSUE ignored, iter_cnt unchanged.
REQ-042 Checker forces res_sat=1 on (3,0) -> found=1, sol=(0x0003,0x000), mismatch=1; next start clears mismatch.
REQ-043 rst_n asserted in WAIT -> same-cycle busy=0, cand_valid=0; no activity until start.
